// File: rtl/cfg_seq_master.sv
// cfg_seq_master: register-interface initiator. It writes a configuration
// table to a CSR target, writes the execute strobe, then polls the status
// register until bit 0 (done) is set.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   start_i                   start pulse (ignored while busy_o)
//   tbl_idx_o                 table read index
//   tbl_addr_i/tbl_data_i     combinational table entry at tbl_idx_o
//   tbl_last_i                entry at tbl_idx_o is the final one
//   reg_req_o / reg_rsp_i     register bus request / response
//   busy_o, done_o, error_o   status (done_o pulses, error_o is sticky)
//   wr_count_o                table writes accepted in current/last run
//
// Optional build macro: CFG_SEQ_TIMEOUT_EN bounds POLL to POLL_TIMEOUT reads.

typedef struct packed {
  logic [31:0] addr;
  logic        write;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        valid;
} cfg_seq_req_t;

typedef struct packed {
  logic [31:0] rdata;
  logic        error;
  logic        ready;
} cfg_seq_rsp_t;

module cfg_seq_master #(
  parameter type         reg_req_t    = cfg_seq_req_t,
  parameter type         reg_rsp_t    = cfg_seq_rsp_t,
  parameter int unsigned NUM_ENTRIES  = 16,
  parameter logic [31:0] EXEC_ADDR    = 32'h50,
  parameter logic [31:0] DONE_ADDR    = 32'h50,
  parameter int unsigned POLL_TIMEOUT = 1024,
  localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic [IDX_W-1:0]  tbl_idx_o,
  input  logic [31:0]       tbl_addr_i,
  input  logic [31:0]       tbl_data_i,
  input  logic              tbl_last_i,
  output reg_req_t          reg_req_o,
  input  reg_rsp_t          reg_rsp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [CNT_W-1:0]  wr_count_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_POLL   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]       state, state_d;
  reg_req_t         req_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic             cur_last, cur_last_d;
  logic             err_d;
  logic [CNT_W-1:0] cnt_d;
  logic             hs;
  logic             ent_end;
  logic             load_entry;
  logic             abort;

`ifdef CFG_SEQ_TIMEOUT_EN
  localparam int unsigned PC_W = $clog2(POLL_TIMEOUT + 1);
  logic [PC_W-1:0] poll_cnt, poll_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^POLL_TIMEOUT;
`endif

  logic unused_rdata;
  assign unused_rdata = ^reg_rsp_i.rdata[31:1];

  assign hs        = reg_req_o.valid & reg_rsp_i.ready;
  assign ent_end   = tbl_last_i || (idx == IDX_W'(NUM_ENTRIES - 1));
  assign tbl_idx_o = idx;
  assign busy_o    = (state != S_IDLE);
  assign done_o    = (state == S_FINISH);

  // The table is read one entry ahead: idx points at the entry that will be
  // loaded next, and the end-of-table decision for the in-flight write is
  // captured in cur_last when that write is loaded. This lets the next write
  // follow its predecessor's handshake with no idle cycle. idx returns to 0
  // as soon as the final entry is loaded, so it reads 0 whenever IDLE.
  always_comb begin
    state_d    = state;
    req_d      = reg_req_o;
    idx_d      = idx;
    cur_last_d = cur_last;
    err_d      = error_o;
    cnt_d      = wr_count_o;
    load_entry = 1'b0;
    abort      = 1'b0;
`ifdef CFG_SEQ_TIMEOUT_EN
    poll_cnt_d = poll_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_WRITE;
          err_d      = 1'b0;
          cnt_d      = '0;
          load_entry = 1'b1;
        end
      end
      S_WRITE: begin
        if (hs) begin
          if (reg_rsp_i.error) begin
            abort = 1'b1;
          end else begin
            if (wr_count_o != CNT_W'(NUM_ENTRIES)) cnt_d = wr_count_o + CNT_W'(1);
            if (cur_last) begin
              state_d     = S_EXEC;
              req_d       = '0;
              req_d.addr  = EXEC_ADDR;
              req_d.write = 1'b1;
              req_d.wdata = 32'h1;
              req_d.wstrb = 4'hF;
              req_d.valid = 1'b1;
            end else begin
              load_entry = 1'b1;
            end
          end
        end
      end
      S_EXEC: begin
        if (hs) begin
          if (reg_rsp_i.error) begin
            abort = 1'b1;
          end else begin
            state_d     = S_POLL;
            req_d       = '0;
            req_d.addr  = DONE_ADDR;
            req_d.valid = 1'b1;
`ifdef CFG_SEQ_TIMEOUT_EN
            poll_cnt_d  = '0;
`endif
          end
        end
      end
      S_POLL: begin
        if (hs) begin
          if (reg_rsp_i.error) begin
            abort = 1'b1;
          end else if (reg_rsp_i.rdata[0]) begin
            state_d = S_FINISH;
            req_d   = '0;
          end else begin
`ifdef CFG_SEQ_TIMEOUT_EN
            if (poll_cnt == PC_W'(POLL_TIMEOUT - 1)) abort = 1'b1;
            else poll_cnt_d = poll_cnt + PC_W'(1);
`endif
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        req_d   = '0;
        idx_d   = '0;
      end
    endcase

    if (load_entry) begin
      req_d       = '0;
      req_d.addr  = tbl_addr_i;
      req_d.write = 1'b1;
      req_d.wdata = tbl_data_i;
      req_d.wstrb = 4'hF;
      req_d.valid = 1'b1;
      cur_last_d  = ent_end;
      idx_d       = ent_end ? '0 : idx + IDX_W'(1);
    end

    if (abort) begin
      state_d = S_IDLE;
      req_d   = '0;
      idx_d   = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      reg_req_o  <= '0;
      idx        <= '0;
      cur_last   <= 1'b0;
      error_o    <= 1'b0;
      wr_count_o <= '0;
`ifdef CFG_SEQ_TIMEOUT_EN
      poll_cnt   <= '0;
`endif
    end else begin
      state      <= state_d;
      reg_req_o  <= req_d;
      idx        <= idx_d;
      cur_last   <= cur_last_d;
      error_o    <= err_d;
      wr_count_o <= cnt_d;
`ifdef CFG_SEQ_TIMEOUT_EN
      poll_cnt   <= poll_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_cfg_seq_master.sv
// Self-checking bench for cfg_seq_master (NUM_ENTRIES = 4, POLL_TIMEOUT = 8).
// A bus responder checks every valid request against a queue of expected
// requests; ready stalls, error responses and done-on-Nth-read are injected.
module tb_cfg_seq_master;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  tbl_idx;
  logic [31:0] tbl_addr, tbl_data;
  logic        tbl_last;
  logic [69:0] req;
  logic [33:0] rsp = '0;
  logic        busy, done, error;
  logic [2:0]  wr_count;

  logic [31:0] t_addr [N];
  logic [31:0] t_data [N];
  logic        t_last [N];

  logic [69:0] exp_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  // responder controls and statistics
  int          done_after = 0;
  int          stall_left = 0;
  logic [31:0] stall_addr = '0;
  bit          err_en = 0;
  logic [31:0] err_addr = '0;
  int          poll_reads = 0;
  int          hs_cnt = 0;
  int          valid_cycles = 0;
  int          done_cnt = 0;
  bit          done_due = 0;
  bit          err_due = 0;

  always #5 clk = ~clk;

  assign tbl_addr = t_addr[tbl_idx];
  assign tbl_data = t_data[tbl_idx];
  assign tbl_last = t_last[tbl_idx];

  cfg_seq_master #(
    .NUM_ENTRIES (N),
    .EXEC_ADDR   (32'h50),
    .DONE_ADDR   (32'h50),
    .POLL_TIMEOUT(8)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .tbl_idx_o (tbl_idx),
    .tbl_addr_i(tbl_addr),
    .tbl_data_i(tbl_data),
    .tbl_last_i(tbl_last),
    .reg_req_o (req),
    .reg_rsp_i (rsp),
    .busy_o    (busy),
    .done_o    (done),
    .error_o   (error),
    .wr_count_o(wr_count)
  );

  task automatic check_eq(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [69:0] mk(input logic [31:0] a, input logic w,
                                     input logic [31:0] d, input logic [3:0] s);
    return {a, w, d, s, 1'b1};
  endfunction

  // Bus responder and scoreboard, evaluated on the falling edge so the
  // response is settled before the DUT samples it on the rising edge.
  initial begin
    logic        ready, err, rd;
    forever begin
      @(negedge clk);
      if (done_due) begin
        check_eq("done_after_last_poll", done, 1);
        done_due = 0;
      end
      if (err_due) begin
        check_eq("idle_after_error", {busy, error}, 2'b01);
        err_due = 0;
      end
      if (done) done_cnt++;
      ready = 1'b1;
      err   = 1'b0;
      rd    = 1'b0;
      if (rst_n && req[0]) begin
        valid_cycles++;
        if (req[37] && stall_left > 0 && req[69:38] == stall_addr) begin
          ready = 1'b0;
          stall_left--;
        end
        if (req[37] && err_en && req[69:38] == err_addr) err = 1'b1;
        if (!req[37]) rd = (done_after != 0) && (poll_reads + 1 >= done_after);
        if (exp_q.size() == 0) check_eq("unexpected_req", req, '0);
        else                   check_eq("req", req, exp_q[0]);
        if (ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          hs_cnt++;
          if (err) err_due = 1;
          else if (!req[37]) begin
            poll_reads++;
            if (rd) done_due = 1;
          end
        end
      end
      rsp = {31'b0, rd, err, ready};
    end
  end

  task automatic clear_stats();
    poll_reads = 0; hs_cnt = 0; valid_cycles = 0; done_cnt = 0;
    stall_left = 0; err_en = 0;
  endtask

  task automatic set_tbl3();
    t_addr[0] = 32'h10; t_data[0] = 32'h8000_0000; t_last[0] = 0;
    t_addr[1] = 32'h14; t_data[1] = 32'h0004_0050; t_last[1] = 0;
    t_addr[2] = 32'h30; t_data[2] = 32'h9000_0000; t_last[2] = 1;
    t_addr[3] = 32'hEC; t_data[3] = 32'hDEAD_BEEF; t_last[3] = 0;
  endtask

  task automatic set_tbl4();
    for (int i = 0; i < 4; i++) begin
      t_addr[i] = 32'h20 + 32'(4 * i);
      t_data[i] = 32'hA000_0000 + 32'(i);
      t_last[i] = 0;
    end
  endtask

  task automatic push_writes(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(t_addr[i], 1'b1, t_data[i], 4'hF));
  endtask

  task automatic push_exec_polls(input int p);
    exp_q.push_back(mk(32'h50, 1'b1, 32'h1, 4'hF));
    for (int i = 0; i < p; i++) exp_q.push_back(mk(32'h50, 1'b0, 32'h0, 4'h0));
  endtask

  // mode 0: plain run; 1: start_i again in the done_o cycle; 2: start_i mid-run
  task automatic run_seq(input int mode);
    int  n;
    bit  got_done;
    n = 0;
    got_done = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_eq("error_cleared_on_start", error, 0);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
      if (mode == 2 && n == 2) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n++;
      end
      if (mode == 1 && done && !got_done) begin
        got_done = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_at_done_ignored", busy, 0);
      end
    end
    check_eq("run_bounded", n < 300, 1);
    @(negedge clk);
  endtask

  initial begin
    set_tbl3();
    repeat (2) @(negedge clk);
    check_eq("rst_req", req, '0);
    check_eq("rst_status", {busy, done, error}, 3'b000);
    check_eq("rst_idx", tbl_idx, 0);
    check_eq("rst_count", wr_count, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // three-entry table, ready always high, done on 2nd read
    clear_stats(); done_after = 2;
    push_writes(3); push_exec_polls(2);
    run_seq(0);
    check_eq("t1_done_count", done_cnt, 1);
    check_eq("t1_wr_count", wr_count, 3);
    check_eq("t1_handshakes", hs_cnt, 6);
    check_eq("t1_valid_cycles", valid_cycles, 6);
    check_eq("t1_queue_empty", exp_q.size(), 0);
    check_eq("t1_error", error, 0);

    // ready stalled 3 cycles on entry 1, plus a start pulse while busy
    clear_stats(); done_after = 1;
    stall_left = 3; stall_addr = 32'h14;
    push_writes(3); push_exec_polls(1);
    run_seq(2);
    check_eq("t2_valid_cycles", valid_cycles, 8);
    check_eq("t2_handshakes", hs_cnt, 5);
    check_eq("t2_wr_count", wr_count, 3);
    check_eq("t2_done_count", done_cnt, 1);
    check_eq("t2_queue_empty", exp_q.size(), 0);

    // error response on entry 2 of 4
    set_tbl4();
    clear_stats(); done_after = 1;
    err_en = 1; err_addr = 32'h24;
    push_writes(2);
    run_seq(0);
    check_eq("t3_error", error, 1);
    check_eq("t3_wr_count", wr_count, 1);
    check_eq("t3_done_count", done_cnt, 0);
    check_eq("t3_queue_empty", exp_q.size(), 0);
    check_eq("t3_handshakes", hs_cnt, 2);

    // no tbl_last: runs to the end of the 4-entry table
    clear_stats(); done_after = 1;
    push_writes(4); push_exec_polls(1);
    run_seq(0);
    check_eq("t4_wr_count", wr_count, 4);
    check_eq("t4_done_count", done_cnt, 1);
    check_eq("t4_error", error, 0);
    check_eq("t4_queue_empty", exp_q.size(), 0);

`ifdef CFG_SEQ_TIMEOUT_EN
    // done never reported: exactly POLL_TIMEOUT reads then error
    set_tbl3();
    clear_stats(); done_after = 0;
    push_writes(3); push_exec_polls(8);
    run_seq(0);
    check_eq("t5_poll_reads", poll_reads, 8);
    check_eq("t5_error", error, 1);
    check_eq("t5_done_count", done_cnt, 0);
    check_eq("t5_queue_empty", exp_q.size(), 0);
`endif

    // reset during POLL
    set_tbl3();
    clear_stats(); done_after = 0;
    push_writes(3); push_exec_polls(20);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 200 && poll_reads < 3; i++) @(negedge clk);
    check_eq("t6_reached_poll", poll_reads >= 3, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_req", req, '0);
    check_eq("t6_rst_status", {busy, done, error}, 3'b000);
    check_eq("t6_rst_idx", tbl_idx, 0);
    check_eq("t6_rst_count", wr_count, 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    done_due = 0;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t6_no_done", done_cnt, 0);

    // clean run after reset, with start_i repeated in the done_o cycle
    clear_stats(); done_after = 2;
    push_writes(3); push_exec_polls(2);
    run_seq(1);
    check_eq("t7_done_count", done_cnt, 1);
    check_eq("t7_wr_count", wr_count, 3);
    check_eq("t7_queue_empty", exp_q.size(), 0);
    check_eq("t7_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
